// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache line fill controller: state encoding and
// default geometry of the memory port and cache line.
package cache_fill_fsm_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_e;

endpackage

// File: rtl/fill_counter.sv
// Word counter for a line fill: synchronous clear, count enable and a
// terminal-count flag raised on the last word of the line.
module fill_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = &count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, reads the whole line from memory one
// 16-bit word per cycle into the data array, then writes the tag and pulses
// fill_done. The line base is latched once per miss and never changes mid-fill.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  localparam int WORD_BITS = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           mem_data_out,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic [WORD_BITS-1:0]  word_sel,
  output logic [15:0]           cache_data_in,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  // Clears the word index and byte-offset bits to form the line base address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((64'd1 << (WORD_BITS + 1)) - 64'd1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic [WORD_BITS-1:0]  count;
  logic                  count_last;

  fill_counter #(
    .WIDTH (WORD_BITS)
  ) u_fill_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (count),
    .terminal (count_last)
  );

  // Next-state, base capture and per-state memory/array strobes.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    cnt_clear        = 1'b0;
    cnt_enable       = 1'b0;
    mem_enable       = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    word_sel         = '0;
    cache_data_in    = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d    = miss_address & LINE_MASK;
          cnt_clear = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        cnt_enable       = 1'b1;
        mem_enable       = 1'b1;
        // Base has its offset bits clear, so OR-ing the word offset stays inside the line.
        mem_addr         = base_q | ADDR_WIDTH'({count, 1'b0});
        write_data_array = 1'b1;
        word_sel         = count;
        cache_data_in    = mem_data_out;
        if (count_last) begin
          state_d = TAG;
        end
      end
      TAG: begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and line-base registers; reset abandons any partial fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign fsm_busy = (state_q != IDLE);
  assign mem_wr   = 1'b0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: basic fill, top-of-memory line, ignored
// mid-fill miss, reset during fill and back-to-back misses.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic [15:0] mem_data_out;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  word_sel;
  logic [15:0] cache_data_in;
  logic        write_tag_array;
  logic        fill_done;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm #(
    .ADDR_WIDTH (16),
    .LINE_WORDS (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_data_out     (mem_data_out),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .word_sel         (word_sel),
    .cache_data_in    (cache_data_in),
    .write_tag_array  (write_tag_array),
    .fill_done        (fill_done)
  );

  always #5 clk = ~clk;

  // Memory model: word w holds w*3.
  logic [15:0] word_idx;
  assign word_idx     = {1'b0, mem_addr[15:1]};
  assign mem_data_out = word_idx * 16'd3;

  // Invariant watch: never a write strobe, never an odd address.
  always @(negedge clk) begin
    checks++;
    if (mem_wr !== 1'b0 || mem_addr[0] !== 1'b0) begin
      errors++;
      $display("FAIL invariant: mem_wr=%b mem_addr=%h required mem_wr=0 mem_addr[0]=0", mem_wr, mem_addr);
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done, mem_addr, word_sel, cache_data_in} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b en=%b wda=%b wta=%b done=%b addr=%h sel=%0d din=%h required all 0",
               fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done, mem_addr, word_sel, cache_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0 || mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b en=%b required 0 0", fsm_busy, mem_enable);
    end
  endtask

  task automatic test_basic_fill();
    logic [15:0] exp_data [8];
    exp_data = '{16'h1B48, 16'h1B4B, 16'h1B4E, 16'h1B51, 16'h1B54, 16'h1B57, 16'h1B5A, 16'h1B5D};
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h1236;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done} !== 5'b11100) begin
        errors++;
        $display("FAIL basic_fill_strobes[%0d]: got %b required 11100", i,
                 {fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done});
      end
      checks++;
      if (mem_addr !== 16'h1230 + 16'(2 * i) || word_sel !== 3'(i)) begin
        errors++;
        $display("FAIL basic_fill_addr[%0d]: addr=%h sel=%0d required %h %0d", i, mem_addr, word_sel,
                 16'h1230 + 16'(2 * i), i);
      end
      checks++;
      if (cache_data_in !== exp_data[i]) begin
        errors++;
        $display("FAIL basic_fill_data[%0d]: got %h required %h", i, cache_data_in, exp_data[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done} !== 5'b10011 ||
        {mem_addr, word_sel, cache_data_in} !== '0) begin
      errors++;
      $display("FAIL basic_tag: strobes=%b addr=%h sel=%0d din=%h required 10011 0 0 0",
               {fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done}, mem_addr, word_sel, cache_data_in);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0 || fill_done !== 1'b0 || write_tag_array !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_idle: busy=%b done=%b wta=%b required 0 0 0", fsm_busy, fill_done, write_tag_array);
    end
  endtask

  task automatic test_top_line();
    logic [15:0] w;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'hFFFE;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      w = 16'h7FF8 + 16'(i);
      checks++;
      if (mem_addr !== 16'hFFF0 + 16'(2 * i) || word_sel !== 3'(i) || cache_data_in !== w * 16'd3) begin
        errors++;
        $display("FAIL top_line[%0d]: addr=%h sel=%0d din=%h required %h %0d %h", i, mem_addr, word_sel,
                 cache_data_in, 16'hFFF0 + 16'(2 * i), i, w * 16'd3);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (fill_done !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL top_line_tag: done=%b addr=%h required 1 0000", fill_done, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignore_midfill();
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h2000;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_addr !== 16'h2000 + 16'(2 * i) || word_sel !== 3'(i) || fsm_busy !== 1'b1) begin
        errors++;
        $display("FAIL ignore_midfill_addr[%0d]: addr=%h sel=%0d busy=%b required %h %0d 1", i, mem_addr,
                 word_sel, fsm_busy, 16'h2000 + 16'(2 * i), i);
      end
      if (i == 2) begin
        miss_detected = 1'b1; miss_address = 16'h4000;
      end else if (i == 3) begin
        miss_detected = 1'b0; miss_address = 16'h0000;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (fill_done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_midfill_tag: done=%b required 1", fill_done);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (fsm_busy !== 1'b0 || mem_enable !== 1'b0) begin
        errors++;
        $display("FAIL ignore_midfill_no_refill[%0d]: busy=%b en=%b required 0 0", i, fsm_busy, mem_enable);
      end
    end
  endtask

  task automatic test_reset_midfill();
    int tag_seen;
    tag_seen = 0;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h3000;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (word_sel !== 3'd4 || mem_addr !== 16'h3008) begin
      errors++;
      $display("FAIL reset_midfill_pre: sel=%0d addr=%h required 4 3008", word_sel, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done, mem_addr, word_sel, cache_data_in} !== '0) begin
      errors++;
      $display("FAIL reset_midfill_async: busy=%b en=%b addr=%h sel=%0d din=%h required all 0",
               fsm_busy, mem_enable, mem_addr, word_sel, cache_data_in);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (write_tag_array !== 1'b0 || fsm_busy !== 1'b0) tag_seen++;
    end
    checks++;
    if (tag_seen !== 0) begin
      errors++;
      $display("FAIL reset_midfill_no_tag: %0d busy/tag cycles seen required 0", tag_seen);
    end
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h3000;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0000;
    @(negedge clk);
    checks++;
    if (mem_addr !== 16'h3000 || word_sel !== 3'd0 || cache_data_in !== 16'h4800) begin
      errors++;
      $display("FAIL reset_midfill_restart: addr=%h sel=%0d din=%h required 3000 0 4800", mem_addr, word_sel, cache_data_in);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midfill_finish: busy=%b required 0", fsm_busy);
    end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'h0010;
    @(posedge clk); #1;
    miss_address = 16'h0020;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (fill_done === 1'b1) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c == 0) begin
        checks++;
        if (mem_addr !== 16'h0010 || word_sel !== 3'd0) begin
          errors++;
          $display("FAIL b2b_first_start: addr=%h sel=%0d required 0010 0", mem_addr, word_sel);
        end
      end
      if (c == 9) begin
        checks++;
        if (fsm_busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap: busy=%b required 0", fsm_busy);
        end
      end
      if (c == 10) begin
        checks++;
        if (mem_addr !== 16'h0020 || word_sel !== 3'd0 || fsm_busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_start: addr=%h sel=%0d busy=%b required 0020 0 1", mem_addr, word_sel, fsm_busy);
        end
        miss_detected = 1'b0; miss_address = 16'h0000;
      end
      if (c == 17) begin
        checks++;
        if (mem_addr !== 16'h002E || word_sel !== 3'd7) begin
          errors++;
          $display("FAIL b2b_second_last: addr=%h sel=%0d required 002E 7", mem_addr, word_sel);
        end
      end
    end
    checks++;
    if (first_done !== 8 || second_done !== 18) begin
      errors++;
      $display("FAIL b2b_done_spacing: pulses at %0d and %0d required 8 and 18", first_done, second_done);
    end
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_idle: busy=%b required 0", fsm_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_top_line();
    test_ignore_midfill();
    test_reset_midfill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
